hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Tracks pending writes to GPRs x1..x31 and the 4 tracked CSRs (mepc, mstatus, mcause, mtvec; 2-bit code) for instructions in flight between IDU issue and WBU writeback.
- Gates IDU issue when a source operand or destination slot conflicts, or when the in-flight window is full.
- Replaces per-stage rd comparators with one central counter-based scoreboard shared by the EXU, LSU and WBU paths.

Parameters:
- MAX_INFLIGHT, 3: maximum instructions issued but not yet retired; range 1..7.
- CNT_W, 2: width of each per-register pending counter; must satisfy 2^CNT_W - 1 >= MAX_INFLIGHT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  IDU has a decoded instruction requesting issue
- issue_ready  out  1  scoreboard permits issue this cycle (combinational)
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_rs_used  in  2  bit0 = rs1 read, bit1 = rs2 read
- issue_rd  in  5  destination register
- issue_rd_wen  in  1  instruction writes issue_rd
- issue_csr_rs  in  2  CSR source code
- issue_csr_rs_used  in  1  instruction reads issue_csr_rs
- issue_csr_rd  in  2  CSR destination code
- issue_csr_wen  in  1  instruction writes issue_csr_rd
- wb_valid  in  1  WBU retires one instruction this cycle
- wb_rd  in  5  retiring GPR destination
- wb_rd_wen  in  1  retiring instruction wrote a GPR
- wb_csr_rd  in  2  retiring CSR destination
- wb_csr_wen  in  1  retiring instruction wrote a CSR
- flush  in  1  discard all in-flight tracking (redirect/trap)
- inflight  out  3  current in-flight instruction count
- busy  out  1  inflight != 0

Behaviour:
- State: gpr_cnt[1..31] (CNT_W bits each), csr_cnt[0..3] (CNT_W bits each), inflight counter. x0 is never tracked; any read of x0 is never a hazard, and a write to x0 is ignored on both issue and retire.
- Reset: all counters = 0, inflight = 0, busy = 0, issue_ready = 1.
- Hazard if any of the following holds:
  - (rs_used[0] && rs1 != 0 && gpr_cnt[rs1] != 0)
  - (rs_used[1] && rs2 != 0 && gpr_cnt[rs2] != 0)
  - (csr_rs_used && csr_cnt[csr_rs] != 0)
- Full if inflight == MAX_INFLIGHT, or a write targets a counter already at 2^CNT_W - 1.
- issue_ready = !hazard && !full && !flush. The issue_valid value has no effect on issue_ready.
- Issue fires on issue_valid && issue_ready. On the next edge: inflight += 1, gpr_cnt[rd] += 1 (if rd_wen && rd != 0), csr_cnt[csr_rd] += 1 (if csr_wen).
- Retire fires on wb_valid. On the next edge: inflight -= 1, and the matching counters are decremented.
- Issue and retire in the same cycle are applied together as a net update:
  - same register: counter unchanged;
  - inflight unchanged.
- Retire of a zero counter or retire at inflight == 0 is a protocol error: the counter holds at 0 and an assertion fires in simulation.
- Flush has priority over issue and retire: all counters and inflight clear to 0 on the next edge, and issue_ready = 0 during the flush cycle.
- Retire frees the register starting the cycle after wb_valid (no same-cycle bypass unless WB_BYPASS_EN is defined).
- Latency: hazard clears 1 cycle after the last retiring writer.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined: a source whose counter equals 1 and which is being retired in the same cycle (wb_valid with matching wb_rd/wb_csr_rd and its write-enable set) is treated as not pending, so a dependent instruction issues in the retire cycle.
- When undefined: the dependent instruction waits one extra cycle.
- Full checks and counter arithmetic are identical in both builds.

Test Plan:
- RAW stall: issue rd=5 wen=1; next cycle present rs1=5 used → issue_ready=0. Assert wb_valid wb_rd=5 → issue_ready=1 the following cycle (same cycle with WB_BYPASS_EN).
- x0 immunity: issue rd=0 wen=1, then rs1=0 rs2=0 used → issue_ready=1, gpr_cnt unchanged, inflight=1.
- Window full: 3 issues with distinct rd (1,2,3), no retire → inflight=3, issue_ready=0 for an independent instruction. One wb_valid → inflight=2, issue_ready=1.
- CSR hazard: issue csr_rd=2'b01 csr_wen=1; next instruction with csr_rs=2'b01 used → stalled; csr_rs=2'b10 → issue_ready=1.
- Simultaneous issue/retire: issue rd=7 while retiring rd=7 (cnt=1) → gpr_cnt[7] stays 1, inflight unchanged.
- Flush mid-operation: 2 in flight (rd=4,6), assert flush with issue_valid=1 → issue_ready=0 in that cycle; next cycle all counters 0, inflight=0, busy=0, rs1=4 issues.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Central counter-based RAW/WAW scoreboard for GPRs x1..x31 and four tracked CSRs.
// Optional macro WB_BYPASS_EN: a source retiring this cycle (last writer) is treated as free.
module hazard_scoreboard #(
   parameter int MAX_INFLIGHT = 3,   // 1..7
   parameter int CNT_W        = 2    // 2**CNT_W - 1 >= MAX_INFLIGHT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       issue_valid,
   output logic       issue_ready,
   input  logic [4:0] issue_rs1,
   input  logic [4:0] issue_rs2,
   input  logic [1:0] issue_rs_used,
   input  logic [4:0] issue_rd,
   input  logic       issue_rd_wen,
   input  logic [1:0] issue_csr_rs,
   input  logic       issue_csr_rs_used,
   input  logic [1:0] issue_csr_rd,
   input  logic       issue_csr_wen,
   input  logic       wb_valid,
   input  logic [4:0] wb_rd,
   input  logic       wb_rd_wen,
   input  logic [1:0] wb_csr_rd,
   input  logic       wb_csr_wen,
   input  logic       flush,
   output logic [2:0] inflight,
   output logic       busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Entry 0 of the GPR array is never incremented, so x0 always reads as free.
   logic [CNT_W-1:0] r_gpr_cnt [32];
   logic [CNT_W-1:0] r_csr_cnt [4];
   logic [2:0]       r_inflight;

   logic        w_rs1_byp, w_rs2_byp, w_csr_byp;
   logic        w_rs1_pend, w_rs2_pend, w_csr_pend;
   logic        w_hazard, w_full, w_issue_fire, w_inflight_dec;
   logic [31:0] w_gpr_inc, w_gpr_dec;
   logic [3:0]  w_csr_inc, w_csr_dec;

`ifdef WB_BYPASS_EN
   assign w_rs1_byp = wb_valid && wb_rd_wen && (wb_rd == issue_rs1) && (r_gpr_cnt[issue_rs1] == CNT_ONE);
   assign w_rs2_byp = wb_valid && wb_rd_wen && (wb_rd == issue_rs2) && (r_gpr_cnt[issue_rs2] == CNT_ONE);
   assign w_csr_byp = wb_valid && wb_csr_wen && (wb_csr_rd == issue_csr_rs)
                      && (r_csr_cnt[issue_csr_rs] == CNT_ONE);
`else
   assign w_rs1_byp = 1'b0;
   assign w_rs2_byp = 1'b0;
   assign w_csr_byp = 1'b0;
`endif

   assign w_rs1_pend = issue_rs_used[0] && (issue_rs1 != 5'd0) && (r_gpr_cnt[issue_rs1] != '0) && !w_rs1_byp;
   assign w_rs2_pend = issue_rs_used[1] && (issue_rs2 != 5'd0) && (r_gpr_cnt[issue_rs2] != '0) && !w_rs2_byp;
   assign w_csr_pend = issue_csr_rs_used && (r_csr_cnt[issue_csr_rs] != '0) && !w_csr_byp;
   assign w_hazard   = w_rs1_pend || w_rs2_pend || w_csr_pend;

   // Full ignores a same-cycle retire so the window check is identical in both builds.
   assign w_full = (r_inflight == 3'(MAX_INFLIGHT))
                || (issue_rd_wen && (issue_rd != 5'd0) && (r_gpr_cnt[issue_rd] == CNT_MAX))
                || (issue_csr_wen && (r_csr_cnt[issue_csr_rd] == CNT_MAX));

   assign issue_ready    = !w_hazard && !w_full && !flush;
   assign w_issue_fire   = issue_valid && issue_ready;
   assign w_inflight_dec = wb_valid && (r_inflight != 3'd0);

   always_comb begin
      w_gpr_inc = '0;
      w_gpr_dec = '0;
      w_csr_inc = '0;
      w_csr_dec = '0;
      for (int i = 1; i < 32; i++) begin
         w_gpr_inc[i] = w_issue_fire && issue_rd_wen && (issue_rd == 5'(i));
         w_gpr_dec[i] = wb_valid && wb_rd_wen && (wb_rd == 5'(i)) && (r_gpr_cnt[i] != '0);
      end
      for (int j = 0; j < 4; j++) begin
         w_csr_inc[j] = w_issue_fire && issue_csr_wen && (issue_csr_rd == 2'(j));
         w_csr_dec[j] = wb_valid && wb_csr_wen && (wb_csr_rd == 2'(j)) && (r_csr_cnt[j] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < 32; i++) r_gpr_cnt[i] <= '0;
         for (int j = 0; j < 4; j++)  r_csr_cnt[j] <= '0;
         r_inflight <= 3'd0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            case ({w_gpr_inc[i], w_gpr_dec[i]})
               2'b10:   r_gpr_cnt[i] <= r_gpr_cnt[i] + CNT_ONE;
               2'b01:   r_gpr_cnt[i] <= r_gpr_cnt[i] - CNT_ONE;
               default: r_gpr_cnt[i] <= r_gpr_cnt[i];
            endcase
         end
         for (int j = 0; j < 4; j++) begin
            case ({w_csr_inc[j], w_csr_dec[j]})
               2'b10:   r_csr_cnt[j] <= r_csr_cnt[j] + CNT_ONE;
               2'b01:   r_csr_cnt[j] <= r_csr_cnt[j] - CNT_ONE;
               default: r_csr_cnt[j] <= r_csr_cnt[j];
            endcase
         end
         case ({w_issue_fire, w_inflight_dec})
            2'b10:   r_inflight <= r_inflight + 3'd1;
            2'b01:   r_inflight <= r_inflight - 3'd1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign inflight = r_inflight;
   assign busy     = (r_inflight != 3'd0);

   // Retiring something that was never issued: counters saturate at zero, flag it here.
   a_retire_inflight: assert property (@(posedge clk) disable iff (rst || flush)
      wb_valid |-> (r_inflight != 3'd0));
   a_retire_gpr: assert property (@(posedge clk) disable iff (rst || flush)
      (wb_valid && wb_rd_wen && (wb_rd != 5'd0)) |-> (r_gpr_cnt[wb_rd] != '0));
   a_retire_csr: assert property (@(posedge clk) disable iff (rst || flush)
      (wb_valid && wb_csr_wen) |-> (r_csr_cnt[wb_csr_rd] != '0));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic
// checked against a queue-of-in-flight-instructions reference model.
module tb_hazard_scoreboard;

   localparam int MAXI = 3;
   localparam int CMAX = 3;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid;
   logic       issue_ready;
   logic [4:0] issue_rs1, issue_rs2, issue_rd;
   logic [1:0] issue_rs_used;
   logic       issue_rd_wen;
   logic [1:0] issue_csr_rs, issue_csr_rd;
   logic       issue_csr_rs_used, issue_csr_wen;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic       wb_rd_wen;
   logic [1:0] wb_csr_rd;
   logic       wb_csr_wen;
   logic       flush;
   logic [2:0] inflight;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] rd;
      logic       rd_wen;
      logic [1:0] csr_rd;
      logic       csr_wen;
   } ent_t;
   ent_t q[$];

   hazard_scoreboard #(.MAX_INFLIGHT(MAXI), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs_used(issue_rs_used),
      .issue_rd(issue_rd), .issue_rd_wen(issue_rd_wen),
      .issue_csr_rs(issue_csr_rs), .issue_csr_rs_used(issue_csr_rs_used),
      .issue_csr_rd(issue_csr_rd), .issue_csr_wen(issue_csr_wen),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_wen(wb_rd_wen),
      .wb_csr_rd(wb_csr_rd), .wb_csr_wen(wb_csr_wen),
      .flush(flush), .inflight(inflight), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int m_gpr_cnt(logic [4:0] r);
      int n = 0;
      if (r == 5'd0) return 0;
      foreach (q[k]) if (q[k].rd_wen && q[k].rd == r) n++;
      return n;
   endfunction

   function automatic int m_csr_cnt(logic [1:0] c);
      int n = 0;
      foreach (q[k]) if (q[k].csr_wen && q[k].csr_rd == c) n++;
      return n;
   endfunction

   function automatic bit m_gpr_pend(logic [4:0] r);
      int c = m_gpr_cnt(r);
      if (c == 0) return 1'b0;
      if (BYP && c == 1 && wb_valid && wb_rd_wen && wb_rd == r) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_csr_pend(logic [1:0] r);
      int c = m_csr_cnt(r);
      if (c == 0) return 1'b0;
      if (BYP && c == 1 && wb_valid && wb_csr_wen && wb_csr_rd == r) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit model_ready();
      bit haz, full;
      haz = (issue_rs_used[0] && m_gpr_pend(issue_rs1))
         || (issue_rs_used[1] && m_gpr_pend(issue_rs2))
         || (issue_csr_rs_used && m_csr_pend(issue_csr_rs));
      full = (q.size() == MAXI)
          || (issue_rd_wen && issue_rd != 5'd0 && m_gpr_cnt(issue_rd) == CMAX)
          || (issue_csr_wen && m_csr_cnt(issue_csr_rd) == CMAX);
      return !haz && !full && !flush;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs_used = 0;
      issue_rd = 0; issue_rd_wen = 0; issue_csr_rs = 0; issue_csr_rs_used = 0;
      issue_csr_rd = 0; issue_csr_wen = 0;
      wb_valid = 0; wb_rd = 0; wb_rd_wen = 0; wb_csr_rd = 0; wb_csr_wen = 0;
      flush = 0;
   endtask

   task automatic drive_wb_oldest();
      wb_valid = 1; wb_rd = q[0].rd; wb_rd_wen = q[0].rd_wen;
      wb_csr_rd = q[0].csr_rd; wb_csr_wen = q[0].csr_wen;
   endtask

   // Advance one clock and apply the same transaction to the model.
   task automatic tick();
      bit   fire;
      ent_t e;
      fire = issue_valid && model_ready();
      e.rd = issue_rd; e.rd_wen = issue_rd_wen; e.csr_rd = issue_csr_rd; e.csr_wen = issue_csr_wen;
      @(posedge clk);
      if (rst || flush) q.delete();
      else begin
         if (wb_valid && q.size() != 0) void'(q.pop_front());
         if (fire) q.push_back(e);
      end
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", issue_ready); end
      tick();
   endtask

   task automatic test_raw();
      do_reset();
      issue_valid = 1; issue_rd = 5; issue_rd_wen = 1;
      @(negedge clk);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_first_issue got %b want 1", issue_ready); end
      tick();
      idle(); issue_valid = 1; issue_rs1 = 5; issue_rs_used = 2'b01;
      @(negedge clk);
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %b want 0", issue_ready); end
      tick();
      drive_wb_oldest();
      @(negedge clk);
      checks++; if (issue_ready !== BYP) begin errors++; $display("FAIL raw_retire_cycle got %b want %b", issue_ready, BYP); end
      tick();
      wb_valid = 0;
      @(negedge clk);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_after_retire got %b want 1", issue_ready); end
      checks++; if (inflight !== 3'(q.size())) begin errors++; $display("FAIL raw_inflight got %0d want %0d", inflight, q.size()); end
      tick();
   endtask

   task automatic test_x0();
      do_reset();
      issue_valid = 1; issue_rd = 0; issue_rd_wen = 1;
      tick();
      idle(); issue_valid = 1; issue_rs_used = 2'b11; issue_rd = 0; issue_rd_wen = 1;
      @(negedge clk);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_read got %b want 1", issue_ready); end
      checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL x0_inflight got %0d want 1", inflight); end
      tick();
   endtask

   task automatic test_full();
      do_reset();
      for (int r = 1; r <= 3; r++) begin
         idle(); issue_valid = 1; issue_rd = 5'(r); issue_rd_wen = 1;
         @(negedge clk);
         checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_fill%0d got %b want 1", r, issue_ready); end
         tick();
      end
      idle(); issue_valid = 1; issue_rs1 = 10; issue_rs_used = 2'b01; issue_rd = 11; issue_rd_wen = 1;
      @(negedge clk);
      checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL full_inflight got %0d want 3", inflight); end
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_stall got %b want 0", issue_ready); end
      tick();
      drive_wb_oldest();
      @(negedge clk);
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_retire_cycle got %b want 0", issue_ready); end
      tick();
      wb_valid = 0;
      @(negedge clk);
      checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL full_after_retire_inflight got %0d want 2", inflight); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_after_retire_ready got %b want 1", issue_ready); end
      tick();
   endtask

   task automatic test_csr();
      do_reset();
      issue_valid = 1; issue_csr_rd = 2'b01; issue_csr_wen = 1;
      tick();
      idle(); issue_valid = 1; issue_csr_rs = 2'b01; issue_csr_rs_used = 1;
      @(negedge clk);
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL csr_stall got %b want 0", issue_ready); end
      tick();
      issue_csr_rs = 2'b10;
      @(negedge clk);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL csr_other got %b want 1", issue_ready); end
      tick();
   endtask

   task automatic test_simul();
      do_reset();
      issue_valid = 1; issue_rd = 7; issue_rd_wen = 1;
      tick();
      drive_wb_oldest();
      @(negedge clk);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got %b want 1", issue_ready); end
      tick();
      idle(); issue_valid = 1; issue_rs1 = 7; issue_rs_used = 2'b01;
      @(negedge clk);
      checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL simul_inflight got %0d want 1", inflight); end
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL simul_pending got %b want 0", issue_ready); end
      tick();
      drive_wb_oldest();
      @(negedge clk);
      checks++; if (issue_ready !== BYP) begin errors++; $display("FAIL simul_retire_cycle got %b want %b", issue_ready, BYP); end
      tick();
      wb_valid = 0; issue_valid = 0;
      @(negedge clk);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL simul_free got %b want 1", issue_ready); end
      checks++; if (inflight !== 3'(q.size())) begin errors++; $display("FAIL simul_final_inflight got %0d want %0d", inflight, q.size()); end
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      issue_valid = 1; issue_rd = 4; issue_rd_wen = 1;
      tick();
      issue_rd = 6;
      tick();
      idle(); issue_valid = 1; flush = 1;
      @(negedge clk);
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", issue_ready); end
      checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL flush_pre_inflight got %0d want 2", inflight); end
      tick();
      idle(); issue_valid = 1; issue_rs1 = 4; issue_rs_used = 2'b01;
      @(negedge clk);
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL flush_inflight got %0d want 0", inflight); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_reissue got %b want 1", issue_ready); end
      tick();
   endtask

   task automatic test_random();
      bit exp_ready;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         issue_valid       = ($urandom_range(0, 3) != 0);
         issue_rs1         = 5'($urandom_range(0, 7));
         issue_rs2         = 5'($urandom_range(0, 7));
         issue_rs_used     = 2'($urandom_range(0, 3));
         issue_rd          = 5'($urandom_range(0, 7));
         issue_rd_wen      = ($urandom_range(0, 3) != 0);
         issue_csr_rs      = 2'($urandom_range(0, 3));
         issue_csr_rs_used = ($urandom_range(0, 3) == 0);
         issue_csr_rd      = 2'($urandom_range(0, 3));
         issue_csr_wen     = ($urandom_range(0, 3) == 0);
         flush             = ($urandom_range(0, 39) == 0);
         if (q.size() != 0 && $urandom_range(0, 2) != 0) drive_wb_oldest();
         else begin
            wb_valid = 0; wb_rd = 5'($urandom_range(0, 31)); wb_rd_wen = 1'($urandom_range(0, 1));
            wb_csr_rd = 2'($urandom_range(0, 3)); wb_csr_wen = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         exp_ready = model_ready();
         checks++; if (issue_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cycle %0d got %b want %b", n, issue_ready, exp_ready); end
         checks++; if (inflight !== 3'(q.size())) begin errors++; $display("FAIL rand_inflight cycle %0d got %0d want %0d", n, inflight, q.size()); end
         checks++; if (busy !== (q.size() != 0)) begin errors++; $display("FAIL rand_busy cycle %0d got %b want %b", n, busy, q.size() != 0); end
         tick();
      end
   endtask

   initial begin
      idle();
      rst = 1;
      #1;
      test_reset();
      test_raw();
      test_x0();
      test_full();
      test_csr();
      test_simul();
      test_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
